// File: rtl/mac_array_seq_if.sv
// rtl/mac_array_seq_if.sv - weight, activation and result stream bundle for mac_array_seq
`timescale 1ns/1ps
interface mac_array_seq_if #(
  parameter int ACC_W = 16
);
  logic               w_valid;
  logic               w_ready;
  logic [4*ACC_W-1:0] w_data;
  logic               act_valid;
  logic               act_ready;
  logic [ACC_W-1:0]   act_data;
  logic               res_valid;
  logic               res_ready;
  logic [4*ACC_W-1:0] res_data;

  modport slave (
    input  w_valid, w_data, act_valid, act_data, res_ready,
    output w_ready, act_ready, res_valid, res_data
  );

  modport master (
    output w_valid, w_data, act_valid, act_data, res_ready,
    input  w_ready, act_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - job sequencer for the 2x2 weight-stationary MAC array
// Define MAC_ARRAY_SEQ_PERF_EN to build the activation-stall counter behind perf_stall.
`timescale 1ns/1ps
module mac_array_seq #(
  parameter int ACC_W     = 16,
  parameter int N_MACS    = 4,
  parameter int KW        = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KW-1:0]       cfg_k,
  input  logic [3*N_MACS-1:0] cfg_route,
  output logic                busy,
  output logic                done,
  output logic                err,
  mac_array_seq_if.slave      bus,
  output logic [3*N_MACS-1:0] arr_valid_ctrl,
  output logic [N_MACS-1:0]   arr_clear,
  output logic [N_MACS-1:0]   arr_valid_weight,
  output logic [ACC_W-1:0]    arr_a_in,
  output logic [4*ACC_W-1:0]  arr_w,
  input  logic [4*ACC_W-1:0]  arr_acc,
  output logic [15:0]         perf_stall
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t              state;
  logic [KW-1:0]       k_q;
  logic [KW-1:0]       beat_cnt;
  logic [3*N_MACS-1:0] route_q;
  logic [DW-1:0]       drain_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      k_q              <= '0;
      beat_cnt         <= '0;
      route_q          <= '0;
      drain_cnt        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      bus.w_ready      <= 1'b0;
      bus.act_ready    <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.res_data     <= '0;
      arr_valid_ctrl   <= '0;
      arr_clear        <= '0;
      arr_valid_weight <= '0;
      arr_a_in         <= '0;
      arr_w            <= '0;
    end else begin
      done             <= 1'b0;
      err              <= 1'b0;
      arr_clear        <= '0;
      arr_valid_weight <= '0;
      arr_valid_ctrl   <= '0;
      // abort wins over any handshake presented in the same cycle
      if (state != S_IDLE && abort) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        done          <= 1'b1;
        err           <= 1'b1;
        arr_clear     <= '1;
        bus.w_ready   <= 1'b0;
        bus.act_ready <= 1'b0;
        bus.res_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_k != '0) begin
                k_q       <= cfg_k;
                route_q   <= cfg_route;
                beat_cnt  <= '0;
                busy      <= 1'b1;
                arr_clear <= '1;
                state     <= S_CLEAR;
              end else begin
                done <= 1'b1;
                err  <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            bus.w_ready <= 1'b1;
            state       <= S_LOAD_W;
          end
          S_LOAD_W: begin
            if (bus.w_valid && bus.w_ready) begin
              bus.w_ready      <= 1'b0;
              arr_w            <= bus.w_data;
              arr_valid_weight <= '1;
              bus.act_ready    <= 1'b1;
              state            <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (bus.act_valid && bus.act_ready) begin
              arr_a_in       <= bus.act_data;
              arr_valid_ctrl <= route_q;
              beat_cnt       <= beat_cnt + 1'b1;
              // drop ready on the final beat so no extra beat is taken
              if (beat_cnt + 1'b1 == k_q) begin
                bus.act_ready <= 1'b0;
                drain_cnt     <= '0;
                state         <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
              bus.res_data  <= arr_acc;
              bus.res_valid <= 1'b1;
              state         <= S_OUTPUT;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          S_OUTPUT: begin
            if (bus.res_valid && bus.res_ready) begin
              bus.res_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MAC_ARRAY_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall <= '0;
    end else if (state == S_IDLE && start && cfg_k != '0) begin
      perf_stall <= '0;
    end else if (state == S_STREAM && !bus.act_valid && perf_stall != 16'hFFFF) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`else
  assign perf_stall = '0;
`endif

endmodule
